idma_rd_arb: RTL
================

IDMA_RD_ARB -- requirements
Module: idma_rd_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of read channels; 2 <= NUM_CH <= 2^AXI_IDW.
REQ-002 SHALL have parameter AXI_DATA_WID, default 256, R data width.
REQ-003 SHALL have parameter AXI_ADDR_WID, default 32, address width.
REQ-004 SHALL have parameter AXI_IDW, default 4, ID width.
REQ-005 SHALL have parameter AXI_LENW, default 4, burst length width.
REQ-006 SHALL use one clock, aclk, and a synchronous active-high reset, areset: aclk input 1 clock; areset input 1 reset.
REQ-007 SHALL have the channel AR ports: ch_arvalid input NUM_CH; ch_araddr input NUM_CH*AXI_ADDR_WID; ch_arlen input NUM_CH*AXI_LENW; ch_arready output NUM_CH.
REQ-008 SHALL have the config ports: cfg_outstd input 4, per-channel outstanding limit minus 1; cfg_outstd_en input 1, limit enable.
REQ-009 SHALL have the AXI AR ports: arvalid output 1; arid output AXI_IDW; araddr output AXI_ADDR_WID; arlen output AXI_LENW; arsize output 3; arburst output 2; arready input 1.
REQ-010 SHALL have the AXI R ports: rvalid input 1; rid input AXI_IDW; rlast input 1; rdata input AXI_DATA_WID; rresp input 2; rready output 1.
REQ-011 SHALL have the channel R ports: ch_rvalid output NUM_CH; ch_rdata output AXI_DATA_WID (shared); ch_rlast output 1; ch_rresp output 2; ch_rready input NUM_CH.
REQ-012 SHALL have the status ports: ch_outstd_cnt output NUM_CH*5, per-channel outstanding bursts; rid_err output 1, sticky error.

Function
REQ-013 Channel i SHALL be eligible when ch_arvalid[i] and (cfg_outstd_en==0 or cnt[i] < cfg_outstd+1).
REQ-014 Arbitration SHALL be round-robin: the search starts at ptr; after each accepted grant g, ptr SHALL become (g+1) mod NUM_CH.
REQ-015 The AR output SHALL be a single register stage: a grant SHALL load it when it is empty or draining (arvalid&&arready) in the same cycle.
REQ-016 ch_arready[g] SHALL pulse high for exactly the load cycle; the request SHALL appear on arvalid the next cycle (1-cycle latency).
REQ-017 arvalid, araddr, arlen and arid SHALL hold stable until arready; arid SHALL be the zero-extended channel index.
REQ-018 arsize SHALL be the constant log2(AXI_DATA_WID/8) and arburst SHALL be the constant 2'b01 (INCR).
REQ-019 The R path SHALL be combinational: ch_rvalid[rid]=rvalid, others 0; rready=ch_rready[rid]; ch_rdata/ch_rlast/ch_rresp SHALL pass through rdata/rlast/rresp.
REQ-020 If rid >= NUM_CH, rready SHALL be 1 (beat dropped), all ch_rvalid SHALL be 0, and rid_err SHALL set.
REQ-021 cnt[arid] SHALL increment on AR handshake; cnt[rid] SHALL decrement on R handshake with rlast; both on the same channel in the same cycle SHALL leave it unchanged.
REQ-022 An rlast handshake with cnt==0 SHALL keep cnt at 0 and set rid_err.
REQ-023 rid_err SHALL clear only on reset.

Reset
REQ-024 areset SHALL clear arvalid, ch_arready, ptr, all cnt and rid_err to 0 at the next aclk edge, including mid-burst; in-flight AR SHALL be discarded.
REQ-025 araddr, arlen and arid SHALL reset to 0.

Configuration
REQ-026 Macro IDMA_RD_ARB_PRIO_EN SHALL, when defined, add input ch_prio (NUM_CH): eligible channels with ch_prio set SHALL win over others, round-robin within each class using the shared ptr.
REQ-027 Without IDMA_RD_ARB_PRIO_EN, port ch_prio SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-028 All 4 ch_arvalid held high, arready=1 -> grants 0,1,2,3,0 on consecutive cycles; arid follows.
REQ-029 arready low for 5 cycles with channel 2 pending -> arvalid/araddr/arid stable 5 cycles; no further ch_arready pulse.
REQ-030 cfg_outstd_en=1, cfg_outstd=1, channel 0 only -> 2 ARs issued, third blocked until one rlast on rid=0; cnt 2->1->2.
REQ-031 rid=5 rvalid with NUM_CH=4 -> rready=1, ch_rvalid=0, rid_err=1 and held.
REQ-032 AR handshake for ch1 and rlast on rid=1 same cycle -> cnt[1] unchanged.
REQ-033 With IDMA_RD_ARB_PRIO_EN, ch_prio=4'b1000, all valid -> ch3 granted each accepted cycle while eligible.

Source files
------------

// File: rtl/idma_rd_arb.sv
// Read-channel arbiter for an iDMA engine: round-robin AR muxing onto one AXI port and rid-based R demux.
// Optional macro IDMA_RD_ARB_PRIO_EN adds a per-channel priority input (ch_prio).
module idma_rd_arb #(
  parameter int NUM_CH       = 4,
  parameter int AXI_DATA_WID = 256,
  parameter int AXI_ADDR_WID = 32,
  parameter int AXI_IDW      = 4,
  parameter int AXI_LENW     = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_CH-1:0]              ch_arvalid,
  input  logic [NUM_CH*AXI_ADDR_WID-1:0] ch_araddr,
  input  logic [NUM_CH*AXI_LENW-1:0]     ch_arlen,
  output logic [NUM_CH-1:0]              ch_arready,
`ifdef IDMA_RD_ARB_PRIO_EN
  input  logic [NUM_CH-1:0]              ch_prio,
`endif
  input  logic [3:0]                     cfg_outstd,
  input  logic                           cfg_outstd_en,
  output logic                           arvalid,
  output logic [AXI_IDW-1:0]             arid,
  output logic [AXI_ADDR_WID-1:0]        araddr,
  output logic [AXI_LENW-1:0]            arlen,
  output logic [2:0]                     arsize,
  output logic [1:0]                     arburst,
  input  logic                           arready,
  input  logic                           rvalid,
  input  logic [AXI_IDW-1:0]             rid,
  input  logic                           rlast,
  input  logic [AXI_DATA_WID-1:0]        rdata,
  input  logic [1:0]                     rresp,
  output logic                           rready,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [AXI_DATA_WID-1:0]        ch_rdata,
  output logic                           ch_rlast,
  output logic [1:0]                     ch_rresp,
  input  logic [NUM_CH-1:0]              ch_rready,
  output logic [NUM_CH*5-1:0]            ch_outstd_cnt,
  output logic                           rid_err
);

  localparam int              CW       = 5;
  localparam logic [AXI_IDW:0] CH_LIMIT = (AXI_IDW+1)'(NUM_CH);
  localparam logic [2:0]      ARSIZE   = 3'($clog2(AXI_DATA_WID / 8));

  // Handshake rule on every port pair: a transfer happens on a rising aclk edge
  // where valid and ready are both high; valid and payload hold until then.

  logic [AXI_IDW-1:0]      ptr;
  logic [CW-1:0]           cnt [NUM_CH];
  logic [CW:0]             inflight [NUM_CH];
  logic [CW:0]             limit;
  logic [NUM_CH-1:0]       elig;
  logic [AXI_IDW:0]        pick;
  logic                    grant_found;
  logic [AXI_IDW-1:0]      grant_idx;
  logic [AXI_ADDR_WID-1:0] sel_addr;
  logic [AXI_LENW-1:0]     sel_len;
  logic                    ar_load;
  logic                    ar_hs;
  logic                    rid_ok;
  logic                    r_last_hs;
  logic [NUM_CH-1:0]       inc_v;
  logic [NUM_CH-1:0]       dec_v;
  logic [NUM_CH-1:0]       zero_v;
  logic                    underflow;

  // Returns {found, index} of the first set mask bit scanning upward from start.
  function automatic logic [AXI_IDW:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                               input logic [AXI_IDW-1:0] start);
    logic [AXI_IDW:0] res;
    int               idx;
    res = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!res[AXI_IDW] && mask[idx]) res = {1'b1, AXI_IDW'(idx)};
    end
    return res;
  endfunction

  // A request parked in the AR register counts toward its channel's limit,
  // otherwise one extra burst would slip through while the slot drains.
  assign limit = {2'b00, cfg_outstd} + (CW+1)'(1);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      inflight[i] = {1'b0, cnt[i]} +
                    ((arvalid && arid == AXI_IDW'(i)) ? (CW+1)'(1) : (CW+1)'(0));
      elig[i]     = ch_arvalid[i] && (!cfg_outstd_en || inflight[i] < limit);
    end
  end

`ifdef IDMA_RD_ARB_PRIO_EN
  logic [AXI_IDW:0] pick_hi;
  always_comb begin
    pick_hi = rr_pick(elig & ch_prio, ptr);
    pick    = pick_hi[AXI_IDW] ? pick_hi : rr_pick(elig, ptr);
  end
`else
  always_comb begin
    pick = rr_pick(elig, ptr);
  end
`endif

  assign grant_found = pick[AXI_IDW];
  assign grant_idx   = pick[AXI_IDW-1:0];
  assign ar_hs       = arvalid && arready;
  assign ar_load     = grant_found && (!arvalid || arready) && !areset;

  always_comb begin
    ch_arready = '0;
    sel_addr   = '0;
    sel_len    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_arready[i] = ar_load && (grant_idx == AXI_IDW'(i));
      if (grant_idx == AXI_IDW'(i)) begin
        sel_addr = ch_araddr[i*AXI_ADDR_WID +: AXI_ADDR_WID];
        sel_len  = ch_arlen[i*AXI_LENW +: AXI_LENW];
      end
    end
  end

  // Single AR slot: reloads in the same cycle it drains.
  always_ff @(posedge aclk) begin
    if (areset) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      ptr     <= '0;
    end else if (ar_load) begin
      arvalid <= 1'b1;
      arid    <= grant_idx;
      araddr  <= sel_addr;
      arlen   <= sel_len;
      ptr     <= (grant_idx == AXI_IDW'(NUM_CH - 1)) ? '0 : grant_idx + AXI_IDW'(1);
    end else if (ar_hs) begin
      arvalid <= 1'b0;
    end
  end

  assign arsize  = ARSIZE;
  assign arburst = 2'b01;

  // R demux; beats carrying an unknown id are accepted and dropped.
  assign rid_ok = {1'b0, rid} < CH_LIMIT;

  always_comb begin
    ch_rvalid = '0;
    rready    = !rid_ok;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rid == AXI_IDW'(i)) begin
        ch_rvalid[i] = rvalid;
        rready       = ch_rready[i];
      end
    end
  end

  assign ch_rdata  = rdata;
  assign ch_rlast  = rlast;
  assign ch_rresp  = rresp;
  assign r_last_hs = rvalid && rready && rlast && rid_ok;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      inc_v[i]  = ar_hs && (arid == AXI_IDW'(i));
      dec_v[i]  = r_last_hs && (rid == AXI_IDW'(i));
      zero_v[i] = (cnt[i] == '0);
      ch_outstd_cnt[i*CW +: CW] = cnt[i];
    end
    underflow = |(dec_v & ~inc_v & zero_v);
  end

  // Counters saturate at both ends; a burst issued and retired together nets out.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      rid_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (inc_v[i] && !dec_v[i]) begin
          if (cnt[i] != '1) cnt[i] <= cnt[i] + CW'(1);
        end else if (dec_v[i] && !inc_v[i] && !zero_v[i]) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
      if ((rvalid && !rid_ok) || underflow) rid_err <= 1'b1;
    end
  end

endmodule
